// File: rtl/fsqrt_pkg.sv
// Shared definitions for the fsqrt Newton-Raphson refinement stage.
//   state_e  : controller states
//   FRAC_DEF : default fraction width of the internal Q2.FRAC words
//   ONE/THREE: 1.0 and 3.0 in Q2.FRAC_DEF
//   QNAN     : canonical quiet NaN returned for negative operands
package fsqrt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SQ,
    MX,
    UPD,
    FIN,
    RND,
    DONE
  } state_e;

  localparam int          FRAC_DEF = 30;
  localparam logic [31:0] ONE      = 32'd1 << FRAC_DEF;
  localparam logic [31:0] THREE    = 32'd3 << FRAC_DEF;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

endpackage

// File: rtl/fsqrt_nr_mul.sv
// Registered unsigned Q2.FRAC multiplier shared by all refinement steps.
// The operand mux lives in the controller; this block only multiplies,
// rescales by FRAC and registers the result (one cycle latency).
//   clk  : clock
//   rstn : asynchronous active-low reset, clears the product
//   a_i  : operand A, Q2.FRAC
//   b_i  : operand B, Q2.FRAC
//   p_o  : registered (a_i*b_i) >> FRAC, truncated to 32 bits
module fsqrt_nr_mul #(
  parameter int FRAC = 30
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  logic [63:0] full;
  logic [31:0] p_q;

  assign full = {32'd0, a_i} * {32'd0, b_i};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_q <= '0;
    end else begin
      p_q <= 32'(full >> FRAC);
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/fsqrt_newton.sv
// Multi-cycle single-precision square root refinement stage.
// Takes x and its 1/sqrt(x) seed, runs ITER Newton-Raphson steps
// r <- r*(3 - m*r*r)/2 over one shared multiplier and returns sqrt(x) = m*r.
// One operation in flight.
//   clk       : clock
//   rstn      : asynchronous active-low reset (aborts any operation)
//   in_valid  : x/seed valid          in_ready  : idle, can accept
//   x         : IEEE-754 operand      seed      : 1/sqrt(x) estimate
//   out_valid : y valid, held         out_ready : consumer accepts y
//   y         : sqrt(x), IEEE-754     busy      : not idle
module fsqrt_newton
  import fsqrt_pkg::*;
#(
  parameter int ITER = 2,
  parameter int FRAC = FRAC_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  input  logic [31:0] seed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        busy
);

  localparam logic [31:0] K_ONE   = ONE >> (FRAC_DEF - FRAC);
  localparam logic [31:0] K_THREE = THREE >> (FRAC_DEF - FRAC);
  localparam logic [1:0]  IT_LAST = 2'(ITER - 1);

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] seed_q, seed_d;
  logic [31:0] m_q, m_d;
  logic [31:0] r_q, r_d;
  logic [31:0] y_q, y_d;
  logic [7:0]  ye_q, ye_d;
  logic [1:0]  it_q, it_d;
  logic        out_valid_q, out_valid_d;

  logic [31:0] mul_a, mul_b, prod;

  fsqrt_nr_mul #(
    .FRAC(FRAC)
  ) u_mul (
    .clk (clk),
    .rstn(rstn),
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (prod)
  );

  // ---------------------------------------------------------------- decode
  logic [7:0]  e_x;
  logic [7:0]  ye_dec;
  logic [31:0] x_man, m_dec, s_man, r0;
  logic [9:0]  sh;

  always_comb begin
    e_x    = x_q[30:23];
    // (e + 126 + e[0]) >> 1 rewritten so no intermediate bit is dropped:
    // odd e -> e[7:1] + 64, even e -> e[7:1] + 63.
    ye_dec = {1'b0, e_x[7:1]} + 8'd63 + {7'd0, e_x[0]};
    x_man  = K_ONE | ({9'd0, x_q[22:0]} << (FRAC - 23));
    // Even exponent: fold one factor of 2 into m so the exponent halves exactly.
    m_dec  = e_x[0] ? x_man : (x_man << 1);
    s_man  = K_ONE | ({9'd0, seed_q[22:0]} << (FRAC - 23));
    // Relative scale of the seed against 1/sqrt(m); only 0 and -1 are meaningful.
    sh     = {2'b00, seed_q[30:23]} + {2'b00, ye_dec} - 10'd254;
    if (seed_q[31]) begin
      r0 = K_ONE;  // a negative estimate is not usable
    end else if (sh == 10'h3FF) begin
      r0 = s_man >> 1;
    end else if (sh == 10'd0) begin
      r0 = s_man;
    end else begin
      r0 = K_ONE;
    end
  end

  // ---------------------------------------------------------------- round/pack
  logic [31:0] q_c, y_pack;
  logic [22:0] q_man;
  logic        q_rnd;
  logic [23:0] man_sum;

  always_comb begin
    // Truncation can leave m*r a hair under 1.0 when sqrt(m) is ~1; clamp so
    // the mantissa extraction below always sees q in [1,2).
    q_c     = (prod < K_ONE) ? K_ONE : prod;
    q_man   = 23'(q_c >> (FRAC - 23));
    q_rnd   = q_c[FRAC-24];
    man_sum = {1'b0, q_man} + {23'd0, q_rnd};
    if (man_sum[23]) begin
      y_pack = {1'b0, ye_q + 8'd1, 23'd0};
    end else begin
      y_pack = {1'b0, ye_q, man_sum[22:0]};
    end
  end

  // r for SQ/FIN: the seed on the very first square, otherwise the product
  // just produced by UPD, halved.
  logic [31:0] r_cur;
  assign r_cur = (state_q == SQ && it_q == 2'd0) ? r_q : (prod >> 1);

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    seed_d      = seed_q;
    m_d         = m_q;
    r_d         = r_q;
    y_d         = y_q;
    ye_d        = ye_q;
    it_d        = it_q;
    out_valid_d = out_valid_q;
    mul_a       = r_q;
    mul_b       = r_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x;
          seed_d  = seed;
          state_d = LOAD;
        end
      end
      LOAD: begin
        it_d = 2'd0;
        if (e_x == 8'd0) begin
          y_d     = {x_q[31], 31'd0};  // zero / flushed denormal keeps its sign
          state_d = DONE;
        end else if (x_q[31]) begin
          y_d     = QNAN;
          state_d = DONE;
        end else if (e_x == 8'hFF) begin
          y_d     = x_q;
          state_d = DONE;
        end else begin
          m_d     = m_dec;
          r_d     = r0;
          ye_d    = ye_dec;
          state_d = SQ;
        end
      end
      SQ: begin
        mul_a   = r_cur;
        mul_b   = r_cur;
        r_d     = r_cur;
        state_d = MX;
      end
      MX: begin
        mul_a   = m_q;
        mul_b   = prod;
        state_d = UPD;
      end
      UPD: begin
        mul_a = r_q;
        mul_b = K_THREE - prod;
        if (it_q == IT_LAST) begin
          it_d    = 2'd0;
          state_d = FIN;
        end else begin
          it_d    = it_q + 2'd1;
          state_d = SQ;
        end
      end
      FIN: begin
        mul_a   = m_q;
        mul_b   = r_cur;
        state_d = RND;
      end
      RND: begin
        y_d     = y_pack;
        state_d = DONE;
      end
      DONE: begin
        // y is already registered on entry; out_valid follows one cycle later.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      x_q         <= '0;
      seed_q      <= '0;
      m_q         <= '0;
      r_q         <= '0;
      y_q         <= '0;
      ye_q        <= '0;
      it_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      seed_q      <= seed_d;
      m_q         <= m_d;
      r_q         <= r_d;
      y_q         <= y_d;
      ye_q        <= ye_d;
      it_q        <= it_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_fsqrt_newton.sv
module tb_fsqrt_newton;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] seed = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic        busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
  } tv_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } exp_t;

  tv_t  tbl[12];
  exp_t sb[$];

  fsqrt_newton dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .seed     (seed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  function automatic real sp2real(input logic [31:0] b);
    logic [63:0] d;
    d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [31:0] s;
    d = $realtobits(r);
    s = {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    return s + {31'd0, d[28]};
  endfunction

  // Seed-stage model: 1/sqrt(x) truncated to 11 mantissa bits.
  function automatic logic [31:0] seed_of(input logic [31:0] xb);
    logic [63:0] d;
    d = $realtobits(1.0 / $sqrt(sp2real(xb)));
    return {1'b0, 8'(int'(d[62:52]) - 1023 + 127), d[51:41], 12'd0};
  endfunction

  function automatic bit is_special(input logic [31:0] xb);
    return (xb[30:23] == 8'd0) || xb[31] || (xb[30:23] == 8'hFF);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input logic [31:0] act,
                         input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %h want %h..%h", name, act, lo, hi);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Waits (bounded) for out_valid; returns 0 on timeout.
  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
  endtask

  // Drive one operation, score it, complete the handshake.
  task automatic run_op(input string name, input logic [31:0] xv,
                        input logic [31:0] sv, input exp_t e);
    int   k;
    bit   ok;
    exp_t ex;
    wait_idle(ok);
    if (!ok) begin
      timeout({name, " in_ready"});
      return;
    end
    x        = xv;
    seed     = sv;
    in_valid = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    k        = cyc;
    in_valid = 1'b0;
    wait_out(ok);
    if (!ok) begin
      timeout({name, " out_valid"});
      sb.delete();
      return;
    end
    ex = sb.pop_front();
    chk({name, " latency"}, 32'(cyc - k), 32'(ex.lat));
    chk_rng({name, " y"}, y, ex.lo, ex.hi);
    $display("op %s x=%h seed=%h y=%h lat=%0d", name, xv, sv, y, cyc - k);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    int          k;
    bit          ok;
    bit          stray;
    logic [31:0] xv, sv, rf, y_hold;
    exp_t        e;

    tbl[0]  = '{32'h4080_0000, 32'h4000_0000, 10};  // 4.0  -> 2.0
    tbl[1]  = '{32'h4000_0000, 32'h3FB5_04F3, 10};  // 2.0  -> sqrt2
    tbl[2]  = '{32'h3F80_0000, 32'h3F80_0000, 10};  // 1.0  -> 1.0
    tbl[3]  = '{32'h4110_0000, 32'h4040_0000, 10};  // 9.0  -> 3.0
    tbl[4]  = '{32'h3E80_0000, 32'h3F00_0000, 10};  // 0.25 -> 0.5
    tbl[5]  = '{32'h4180_0000, 32'h4080_0000, 10};  // 16.0 -> 4.0
    tbl[6]  = '{32'h8000_0000, 32'h8000_0000, 2};   // -0
    tbl[7]  = '{32'hBF80_0000, 32'h7FC0_0000, 2};   // -1 -> qNaN
    tbl[8]  = '{32'h7F80_0000, 32'h7F80_0000, 2};   // +inf
    tbl[9]  = '{32'h0040_0000, 32'h0000_0000, 2};   // denormal flushed
    tbl[10] = '{32'h7FC0_0000, 32'h7FC0_0000, 2};   // NaN passthrough
    tbl[11] = '{32'hFF80_0000, 32'h7FC0_0000, 2};   // -inf -> qNaN

    repeat (3) @(negedge clk);
    chk1("reset out_valid", out_valid, 1'b0);
    chk("reset y", y, 32'h0);
    chk1("reset busy", busy, 1'b0);
    chk1("reset in_ready", in_ready, 1'b1);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      sv = is_special(tbl[i].x) ? 32'h0 : seed_of(tbl[i].x);
      e  = '{tbl[i].y, tbl[i].y, tbl[i].lat};
      run_op($sformatf("vec%0d", i), tbl[i].x, sv, e);
    end

    // Back-pressure: result held, new input ignored, one-cycle bubble.
    out_ready = 1'b0;
    wait_idle(ok);
    if (!ok) timeout("bp in_ready");
    x        = 32'h4080_0000;
    seed     = seed_of(32'h4080_0000);
    in_valid = 1'b1;
    sb.push_back('{32'h4000_0000, 32'h4000_0000, 10});
    @(negedge clk);
    k        = cyc;
    in_valid = 1'b0;
    wait_out(ok);
    if (!ok) begin
      timeout("bp out_valid");
      sb.delete();
    end else begin
      e = sb.pop_front();
      chk("bp latency", 32'(cyc - k), 32'(e.lat));
      chk("bp y", y, e.lo);
      y_hold = y;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'b1;
        x        = 32'h4000_0000;
        seed     = seed_of(32'h4000_0000);
        @(negedge clk);
        chk1($sformatf("bp hold%0d out_valid", i), out_valid, 1'b1);
        chk($sformatf("bp hold%0d y", i), y, y_hold);
        chk1($sformatf("bp hold%0d in_ready", i), in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk1("bp release out_valid", out_valid, 1'b0);
      chk1("bp release in_ready", in_ready, 1'b1);
      stray = 1'b0;
      repeat (15) begin
        @(negedge clk);
        if (busy || out_valid) stray = 1'b1;
      end
      chk1("bp ignored input", stray, 1'b0);
      $display("op backpressure x=40800000 y=%h held 5 cycles", y_hold);
    end

    // Reset during the first UPD step of an operation.
    wait_idle(ok);
    if (!ok) timeout("rst in_ready");
    x        = 32'h4000_0000;
    seed     = seed_of(32'h4000_0000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk1("rst pre busy", busy, 1'b1);
    #2 rstn = 1'b0;
    #1;
    chk1("rst async out_valid", out_valid, 1'b0);
    chk("rst async y", y, 32'h0);
    chk1("rst async busy", busy, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    $display("op reset_mid_op aborted");
    run_op("post_reset", 32'h4000_0000, seed_of(32'h4000_0000),
           '{32'h3FB5_04F3, 32'h3FB5_04F3, 10});

    // Out-of-range seed for 100.0: seed ignored, r0 = 1.0; two steps land near 10.
    run_op("bad_seed", 32'h42C8_0000, 32'h3F80_0000, '{32'h4110_0000, 32'h4120_0000, 10});

    // Random normals against a double-precision reference, within 1 ulp.
    for (int i = 0; i < 300; i++) begin
      xv = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
      rf = real2sp($sqrt(sp2real(xv)));
      run_op($sformatf("rnd%0d", i), xv, seed_of(xv), '{rf - 32'd1, rf + 32'd1, 10});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
